branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline. It replaces the fixed always-not-taken PC select with a direct-mapped branch target buffer and a table of 2-bit saturating counters. The PHT index is either bimodal (PC-indexed) or gshare (PC XOR global history). The IF stage reads a prediction combinationally from the current PC. The EX stage feeds back each resolved control-flow instruction; the block then trains its tables, raises a mispredict/redirect to the hazard logic, and keeps saturating statistics counters.

---
 rtl/branch_predictor.sv | 109 ++++++++++
 tb/tb_branch_predictor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit counter PHT (bimodal or gshare index) with
// resolution-time training, mispredict/redirect generation and saturating stats.
module branch_predictor #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 25,
  parameter int GHR_BITS   = 5,
  parameter int MODE       = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        upd_valid,
  input  logic        upd_is_cond,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [31:0] upd_pred_next_pc,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int DEPTH = 1 << INDEX_BITS;

  logic                valid_q  [DEPTH];
  logic [TAG_BITS-1:0] tag_q    [DEPTH];
  logic [31:0]         target_q [DEPTH];
  logic                uncond_q [DEPTH];
  logic [1:0]          pht_q    [DEPTH];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         stat_br_q, stat_br_d;
  logic [31:0]         stat_mp_q, stat_mp_d;
  logic [1:0]          pht_d;

  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] pred_idx, pred_pidx, upd_idx, upd_pidx;
  logic [TAG_BITS-1:0]   pred_tag, upd_tag;
  logic                  pred_hit;
  logic [31:0]           actual_next;
  logic [GHR_BITS:0]     ghr_shift;
  logic                  unused_ok;

  assign ghr_ext   = INDEX_BITS'(ghr_q);
  assign pred_idx  = if_pc[INDEX_BITS+1:2];
  assign upd_idx   = upd_pc[INDEX_BITS+1:2];
  assign pred_tag  = if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign upd_tag   = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign pred_pidx = (MODE == 1) ? (pred_idx ^ ghr_ext) : pred_idx;
  assign upd_pidx  = (MODE == 1) ? (upd_idx ^ ghr_ext) : upd_idx;
  assign unused_ok = ^{if_pc, upd_pc};

  // Prediction reads pre-edge state only; an update this cycle is seen next cycle.
  assign pred_hit     = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign pred_taken   = pred_hit && (uncond_q[pred_idx] || pht_q[pred_pidx][1]);
  assign pred_next_pc = pred_taken ? target_q[pred_idx] : if_pc + 32'd4;

  assign actual_next = upd_taken ? upd_target : upd_pc + 32'd4;
  assign mispredict  = upd_valid && (actual_next != upd_pred_next_pc);
  assign redirect_pc = upd_valid ? actual_next : 32'd0;

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

  always_comb begin
    pht_d = pht_q[upd_pidx];
    if (upd_taken && pht_d != 2'b11) begin
      pht_d = pht_d + 2'b01;
    end else if (!upd_taken && pht_d != 2'b00) begin
      pht_d = pht_d - 2'b01;
    end
    ghr_shift = {ghr_q, upd_taken};
    ghr_d     = ghr_shift[GHR_BITS-1:0];
    stat_br_d = (stat_br_q == 32'hFFFF_FFFF) ? stat_br_q : stat_br_q + 32'd1;
    stat_mp_d = (mispredict && stat_mp_q != 32'hFFFF_FFFF) ? stat_mp_q + 32'd1 : stat_mp_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        pht_q[i]   <= 2'b01;
      end
      ghr_q     <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (upd_valid) begin
      if (upd_is_cond) begin
        pht_q[upd_pidx] <= pht_d;
        ghr_q           <= ghr_d;
      end
      if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
      end
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  // Payload fields need no reset: valid_q gates every use of them.
  always_ff @(posedge clk) begin
    if (!reset && upd_valid && upd_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
      uncond_q[upd_idx] <= !upd_is_cond;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Drives a bimodal and a gshare (2-bit history) predictor with the same stream
// and checks both against a table-level reference model.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        upd_valid, upd_is_cond, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic [1:0][31:0] pnpc;
  logic [1:0]       pt, mp;
  logic [1:0][31:0] pn, rd, sb, sm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(5), .TAG_BITS(25), .GHR_BITS(5), .MODE(0)) dut_b (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pt[0]), .pred_next_pc(pn[0]),
    .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_next_pc(pnpc[0]),
    .mispredict(mp[0]), .redirect_pc(rd[0]),
    .stat_branches(sb[0]), .stat_mispredicts(sm[0]));

  branch_predictor #(.INDEX_BITS(5), .TAG_BITS(25), .GHR_BITS(2), .MODE(1)) dut_g (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pt[1]), .pred_next_pc(pn[1]),
    .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_next_pc(pnpc[1]),
    .mispredict(mp[1]), .redirect_pc(rd[1]),
    .stat_branches(sb[1]), .stat_mispredicts(sm[1]));

  // Reference model: per-instance tables as plain ints, history as an integer.
  int          m_mode [2] = '{0, 1};
  int          m_hlen [2] = '{5, 2};
  bit          m_valid[2][32];
  logic [31:0] m_tag  [2][32];
  logic [31:0] m_tgt  [2][32];
  bit          m_unc  [2][32];
  int          m_cnt  [2][32];
  int          m_hist [2];
  longint      m_nb   [2];
  longint      m_nm   [2];

  logic        o_pt[2], o_mp[2];
  logic [31:0] o_pn[2], o_rd[2], o_sb[2], o_sm[2];

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) % 32);
  endfunction

  function automatic int m_pidx(int k, logic [31:0] pc);
    return (m_mode[k] == 1) ? (m_idx(pc) ^ m_hist[k]) : m_idx(pc);
  endfunction

  function automatic logic [32:0] m_pred(int k, logic [31:0] pc);
    int  i;
    bit  t;
    i = m_idx(pc);
    t = m_valid[k][i] && (m_tag[k][i] == (pc >> 7)) && (m_unc[k][i] || m_cnt[k][m_pidx(k, pc)] >= 2);
    return {t, t ? m_tgt[k][i] : pc + 32'd4};
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_valid[k][i] = 0;
        m_cnt[k][i]   = 1;
      end
      m_hist[k] = 0;
      m_nb[k]   = 0;
      m_nm[k]   = 0;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic step(bit rst, bit v, bit cond, logic [31:0] pc, bit tk,
                      logic [31:0] tgt, logic [31:0] fpc, bit use_ov, logic [31:0] ov);
    logic [32:0] pr;
    logic [31:0] actual;
    int          pi;
    @(negedge clk);
    reset = rst; if_pc = fpc; upd_valid = v; upd_is_cond = cond;
    upd_pc = pc; upd_taken = tk; upd_target = tgt;
    for (int k = 0; k < 2; k++) begin
      pr = m_pred(k, pc);
      pnpc[k] = use_ov ? ov : pr[31:0];
    end
    actual = tk ? tgt : pc + 32'd4;
    #1;
    for (int k = 0; k < 2; k++) begin
      o_pt[k] = pt[k]; o_pn[k] = pn[k]; o_mp[k] = mp[k];
      o_rd[k] = rd[k]; o_sb[k] = sb[k]; o_sm[k] = sm[k];
      pr = m_pred(k, fpc);
      chk($sformatf("pred_taken[%0d]", k), 64'(pt[k]), 64'(pr[32]));
      chk($sformatf("pred_next_pc[%0d]", k), 64'(pn[k]), 64'(pr[31:0]));
      chk($sformatf("mispredict[%0d]", k), 64'(mp[k]), 64'(v && (actual != pnpc[k])));
      chk($sformatf("redirect_pc[%0d]", k), 64'(rd[k]), v ? 64'(actual) : 64'd0);
      chk($sformatf("stat_branches[%0d]", k), 64'(sb[k]), 64'(m_nb[k]));
      chk($sformatf("stat_mispredicts[%0d]", k), 64'(sm[k]), 64'(m_nm[k]));
    end
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (v) begin
      for (int k = 0; k < 2; k++) begin
        if (m_nb[k] < 64'hFFFF_FFFF) m_nb[k]++;
        if (actual != pnpc[k] && m_nm[k] < 64'hFFFF_FFFF) m_nm[k]++;
        if (cond) begin
          pi = m_pidx(k, pc);
          m_cnt[k][pi] = tk ? ((m_cnt[k][pi] < 3) ? m_cnt[k][pi] + 1 : 3)
                            : ((m_cnt[k][pi] > 0) ? m_cnt[k][pi] - 1 : 0);
          m_hist[k] = (m_hist[k] * 2 + int'(tk)) % (1 << m_hlen[k]);
        end
        if (tk) begin
          m_valid[k][m_idx(pc)] = 1;
          m_tag[k][m_idx(pc)]   = pc >> 7;
          m_tgt[k][m_idx(pc)]   = tgt;
          m_unc[k][m_idx(pc)]   = !cond;
        end
      end
    end
  endtask

  task automatic idle(logic [31:0] fpc);
    step(0, 0, 0, 32'h0, 0, 32'h0, fpc, 0, 32'h0);
  endtask

  initial begin
    int mp_g, mp_b;
    logic [31:0] rpc, rfpc;
    bit rc, rt;
    reset = 1'b1; if_pc = '0; upd_valid = 0; upd_is_cond = 0;
    upd_pc = '0; upd_taken = 0; upd_target = '0; pnpc = '0;
    m_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    idle(32'h40);
    chk("reset_pred_taken", 64'(o_pt[0]), 64'd0);
    chk("reset_pred_pc", 64'(o_pn[0]), 64'h44);
    chk("reset_stat_br", 64'(o_sb[0]), 64'd0);
    chk("reset_stat_mp", 64'(o_sm[0]), 64'd0);

    step(0, 1, 1, 32'h100, 1, 32'h80, 32'h100, 1, 32'h104);
    chk("first_taken_mp", 64'(o_mp[0]), 64'd1);
    chk("first_taken_redirect", 64'(o_rd[0]), 64'h80);
    step(0, 1, 1, 32'h100, 1, 32'h80, 32'h100, 0, 0);
    chk("trained_taken", 64'(o_pt[0]), 64'd1);
    chk("trained_target", 64'(o_pn[0]), 64'h80);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 32'h100, 0, 32'h80, 32'h100, 0, 0);
    step(0, 1, 1, 32'h100, 1, 32'h80, 32'h100, 0, 0);
    chk("nt_floor_pred", 64'(o_pn[0]), 64'h104);
    idle(32'h100);
    chk("sat_at_zero", 64'(o_pn[0]), 64'h104);

    step(0, 1, 0, 32'h200, 1, 32'h400, 32'h0, 0, 0);
    idle(32'h200);
    chk("jal_taken", 64'(o_pt[0]), 64'd1);
    chk("jal_target", 64'(o_pn[0]), 64'h400);
    step(0, 1, 1, 32'h200, 0, 32'h0, 32'h200, 0, 0);
    idle(32'h200);
    chk("jal_kept", 64'(o_pn[0]), 64'h400);

    step(0, 1, 1, 32'h100, 1, 32'h80, 32'h0, 0, 0);
    step(0, 1, 1, 32'h180, 1, 32'h300, 32'h0, 0, 0);
    idle(32'h100);
    chk("alias_miss_taken", 64'(o_pt[0]), 64'd0);
    chk("alias_miss_pc", 64'(o_pn[0]), 64'h104);

    mp_g = 0; mp_b = 0;
    for (int r = 0; r < 32; r++) begin
      step(0, 1, 1, 32'h0, (r % 2) == 0, 32'h40, 32'h0, 0, 0);
      if (r >= 12) begin
        mp_g += int'(o_mp[1]);
        mp_b += int'(o_mp[0]);
      end
    end
    chk("gshare_learned", 64'(mp_g), 64'd0);
    chk("bimodal_keeps_missing", 64'(mp_b > 0), 64'd1);

    for (int n = 0; n < 300; n++) begin
      rpc  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 2);
      rfpc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 2);
      rc   = $urandom_range(0, 2) != 0;
      rt   = rc ? 1'($urandom_range(0, 1)) : 1'b1;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, rc, rpc, rt,
           $urandom & 32'hFFFF_FFFC, rfpc, $urandom_range(0, 4) == 0, $urandom & 32'hFFFF_FFFC);
    end

    step(1, 1, 1, 32'h500, 1, 32'h600, 32'h0, 0, 0);
    idle(32'h500);
    chk("rst_drops_upd_b", 64'(o_pn[0]), 64'h504);
    chk("rst_drops_upd_g", 64'(o_pn[1]), 64'h504);
    chk("rst_drops_stat", 64'(o_sb[0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
